// File: rtl/cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_arbiter_if
// Purpose : one physical-memory line-transfer channel (request strobes,
//           address, write line, returned line, completion).
// Modports:
//   master - the requester side: drives read, write, address, wdata;
//            receives rdata, resp.
//   slave  - the responder side: receives read, write, address, wdata;
//            drives rdata, resp.
// Parameters: ADDR_W address width, LINE_W cache line width.
// -----------------------------------------------------------------------------
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Purpose : shares one physical-memory port between an I-cache and a D-cache.
//           A client is granted in IDLE, owns memory for the whole SERVE state,
//           and every transaction ends with a one-cycle RELEASE in which all
//           strobes are low before the next arbitration.
// Ports   :
//   clk            - single clock, rising edge
//   reset          - synchronous, active-high
//   i_pmem (slave) - I-cache request channel
//   d_pmem (slave) - D-cache request channel
//   pmem  (master) - physical-memory channel
//   conflict_count - saturating count of IDLE cycles with both clients asking
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, ties alternate using a last_grant
//                        register (first tie after reset goes to D); when
//                        undefined, ties always go to the D-cache.
// -----------------------------------------------------------------------------
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_arbiter_if.slave         i_pmem,
  cache_arbiter_if.slave         d_pmem,
  cache_arbiter_if.master        pmem,
  output logic [15:0]            conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       conflict_count_r;
  logic              i_req_s;
  logic              d_req_s;
  logic              tie_to_d_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic [LINE_W-1:0] wdata_mux_s;

  assign i_req_s = i_pmem.read | i_pmem.write;
  assign d_req_s = d_pmem.read | d_pmem.write;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic last_grant_r;

  // A tie goes to whichever client was not granted last time.
  assign tie_to_d_s = (last_grant_r == GRANT_I);

  // Record the client granted on every IDLE-to-SERVE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_I;
    end else if ((state_r == IDLE) && (state_s == SERVE_I)) begin
      last_grant_r <= GRANT_I;
    end else if ((state_r == IDLE) && (state_s == SERVE_D)) begin
      last_grant_r <= GRANT_D;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed priority: the D-cache always wins a tie.
  assign tie_to_d_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: the grant is fixed for the whole SERVE state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          state_s = tie_to_d_s ? SERVE_D : SERVE_I;
        end else if (i_req_s) begin
          state_s = SERVE_I;
        end else if (d_req_s) begin
          state_s = SERVE_D;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem.resp) begin
          state_s = RELEASE;
        end else if (i_req_s) begin
          state_s = SERVE_I;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem.resp) begin
          state_s = RELEASE;
        end else if (d_req_s) begin
          state_s = SERVE_D;
        end else begin
          state_s = IDLE;
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output routing: the served client is connected straight through; a
  // client raising both strobes gets a write, never a simultaneous read.
  always_comb begin
    pmem.read   = 1'b0;
    pmem.write  = 1'b0;
    addr_mux_s  = d_pmem.address;
    wdata_mux_s = d_pmem.wdata;
    i_pmem.resp = 1'b0;
    d_pmem.resp = 1'b0;
    case (state_r)
      SERVE_I: begin
        pmem.read   = i_pmem.read & ~i_pmem.write;
        pmem.write  = i_pmem.write;
        addr_mux_s  = i_pmem.address;
        wdata_mux_s = i_pmem.wdata;
        i_pmem.resp = pmem.resp;
      end
      SERVE_D: begin
        pmem.read   = d_pmem.read & ~d_pmem.write;
        pmem.write  = d_pmem.write;
        addr_mux_s  = d_pmem.address;
        wdata_mux_s = d_pmem.wdata;
        d_pmem.resp = pmem.resp;
      end
      default: begin
        pmem.read   = 1'b0;
        pmem.write  = 1'b0;
      end
    endcase
  end

  assign pmem.address = addr_mux_s;
  assign pmem.wdata   = wdata_mux_s;

  // Returned line goes to both caches; only the resp strobe is steered.
  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;

  // Count IDLE cycles in which both clients request, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_count_r <= 16'h0000;
    end else if ((state_r == IDLE) && i_req_s && d_req_s &&
                 (conflict_count_r != 16'hFFFF)) begin
      conflict_count_r <= conflict_count_r + 16'h0001;
    end else begin
      conflict_count_r <= conflict_count_r;
    end
  end

  assign conflict_count = conflict_count_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
// Purpose : directed self-checking bench for cache_arbiter. Inputs change 1
//           time unit after each rising edge and outputs are sampled 3 time
//           units after it. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic        clk;
  logic        reset;
  logic [15:0] conflict_count;

  int n_checks;
  int n_errors;
  int exp_cc;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) m_bus ();

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem         (i_bus),
    .d_pmem         (d_bus),
    .pmem           (m_bus),
    .conflict_count (conflict_count)
  );

  localparam logic [127:0] W_D  = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] W_1  = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0000_0001;
  localparam logic [127:0] W_2  = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0002;
  localparam logic [127:0] R_1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] R_2  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes and resps all expected as given.
  task automatic check_ctl(input string tag, input logic rd, input logic wr,
                           input logic ir, input logic dr);
    check_eq({tag, "_read"},  m_bus.read,  rd);
    check_eq({tag, "_write"}, m_bus.write, wr);
    check_eq({tag, "_iresp"}, i_bus.resp,  ir);
    check_eq({tag, "_dresp"}, d_bus.resp,  dr);
  endtask

  // Abort a hung run with a failure line.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic win_d;
    n_checks = 0;
    n_errors = 0;
    exp_cc   = 0;
    reset = 1'b1;
    i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.address = '0; i_bus.wdata = '0;
    d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.address = '0; d_bus.wdata = '0;
    m_bus.rdata = '0;  m_bus.resp = 1'b0;

    // Reset state
    tick(); tick(); #2;
    check_eq("rst_cc", conflict_count, 16'h0000);
    check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); reset = 1'b0; #2;

    // I-read only, resp after 3 cycles
    tick();
    d_bus.address = 16'hBEEF; d_bus.wdata = W_D;
    i_bus.read = 1'b1; i_bus.address = 16'h0040; #2;
    check_ctl("ir_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ir_idle_addr", m_bus.address, 16'hBEEF);
    check_eq("ir_idle_wdata", m_bus.wdata, W_D);
    tick(); #2;
    check_ctl("ir_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ir_c1_addr", m_bus.address, 16'h0040);
    tick(); #2;
    check_ctl("ir_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); m_bus.resp = 1'b1; m_bus.rdata = R_1; #2;
    check_ctl("ir_c3", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("ir_irdata", i_bus.rdata, R_1);
    check_eq("ir_drdata", d_bus.rdata, R_1);
    tick(); m_bus.resp = 1'b0; #2;
    check_ctl("ir_release", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); i_bus.read = 1'b0; #2;
    check_ctl("ir_back_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ir_cc", conflict_count, 16'h0000);

    // Simultaneous I-read and D-write: D first
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h0040;
    d_bus.write = 1'b1; d_bus.address = 16'h1230; d_bus.wdata = W_1; #2;
    check_ctl("tie_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("tie_sd", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tie_sd_addr", m_bus.address, 16'h1230);
    check_eq("tie_sd_wdata", m_bus.wdata, W_1);
    check_eq("tie_cc", conflict_count, 16'h0001);
    tick(); m_bus.resp = 1'b1; #2;
    check_ctl("tie_sd_resp", 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); m_bus.resp = 1'b0; d_bus.write = 1'b0; #2;
    check_ctl("tie_release", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("tie_idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("tie_si", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("tie_si_addr", m_bus.address, 16'h0040);
    tick(); m_bus.resp = 1'b1; #2;
    check_ctl("tie_si_resp", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); m_bus.resp = 1'b0; i_bus.read = 1'b0; #2;
    check_ctl("tie_release2", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tie_cc2", conflict_count, 16'h0001);
    tick(); #2;

    // D write-back then D read: two SERVE_D episodes
    tick(); d_bus.write = 1'b1; d_bus.address = 16'h2000; d_bus.wdata = W_2; #2;
    check_ctl("wb_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); m_bus.resp = 1'b1; #2;
    check_ctl("wb_sd", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("wb_addr", m_bus.address, 16'h2000);
    check_eq("wb_wdata", m_bus.wdata, W_2);
    tick(); m_bus.resp = 1'b0; d_bus.write = 1'b0; #2;
    check_ctl("wb_release", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); d_bus.read = 1'b1; d_bus.address = 16'h3000; #2;
    check_ctl("wb_idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); m_bus.resp = 1'b1; m_bus.rdata = R_2; #2;
    check_ctl("fill_sd", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("fill_addr", m_bus.address, 16'h3000);
    check_eq("fill_rdata", d_bus.rdata, R_2);
    tick(); m_bus.resp = 1'b0; d_bus.read = 1'b0; #2;
    check_ctl("fill_release", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("fill_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fill_cc", conflict_count, 16'h0001);

    // Client drops without resp; then illegal read+write from D
    tick(); i_bus.read = 1'b1; i_bus.address = 16'h0500; #2;
    check_ctl("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("drop_si", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); i_bus.read = 1'b0; #2;
    check_ctl("drop_follow", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("drop_addr", m_bus.address, 16'h0500);
    tick(); d_bus.read = 1'b1; d_bus.write = 1'b1; d_bus.address = 16'h0600; #2;
    check_ctl("drop_idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;
    check_ctl("both_strobes", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("both_addr", m_bus.address, 16'h0600);
    tick(); d_bus.read = 1'b0; d_bus.write = 1'b0; #2;
    check_ctl("both_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #2;

    // Three back-to-back ties after a fresh reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; exp_cc = 0;
    i_bus.address = 16'h0100; d_bus.address = 16'h0200;
    i_bus.read = 1'b1; d_bus.read = 1'b1; #2;
    check_eq("rr_cc0", conflict_count, 16'h0000);
    for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = (k != 1);
`else
      win_d = 1'b1;
`endif
      check_ctl("rr_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); m_bus.resp = 1'b1; exp_cc++; #2;
      check_ctl("rr_serve", 1'b1, 1'b0, ~win_d, win_d);
      check_eq("rr_addr", m_bus.address, win_d ? 16'h0200 : 16'h0100);
      check_eq("rr_cc", conflict_count, exp_cc[15:0]);
      tick(); m_bus.resp = 1'b0; #2;
      check_ctl("rr_release", 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); #2;
    end
    i_bus.read = 1'b0; d_bus.read = 1'b0;
    check_eq("rr_cc3", conflict_count, 16'h0003);

    // Saturation: each tie costs an IDLE and a dropped SERVE cycle
    for (int n = 0; n < 65536; n++) begin
      i_bus.read = 1'b1; d_bus.read = 1'b1;
      tick();
      i_bus.read = 1'b0; d_bus.read = 1'b0;
      tick();
      if (exp_cc < 65535) exp_cc++;
      if (n == 65529) begin
        #2;
        check_eq("sat_mid", conflict_count, exp_cc[15:0]);
        check_eq("sat_mid_val", conflict_count, 16'hFFFD);
      end
    end
    #2;
    check_eq("sat_full", conflict_count, 16'hFFFF);
    tick(); i_bus.read = 1'b1; d_bus.read = 1'b1;
    tick(); i_bus.read = 1'b0; d_bus.read = 1'b0;
    tick(); #2;
    check_eq("sat_hold", conflict_count, 16'hFFFF);

    // Reset during SERVE_I before resp
    tick(); i_bus.read = 1'b1; i_bus.address = 16'h0040; #2;
    tick(); #2;
    check_ctl("rst_si", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); reset = 1'b1; #2;
    check_ctl("rst_si2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); reset = 1'b0; #2;
    check_ctl("rst_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_abort_cc", conflict_count, 16'h0000);
    tick(); #2;
    check_ctl("rst_rearb", 1'b1, 1'b0, 1'b0, 1'b0);
    i_bus.read = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
